// File: rtl/wb2axil_bridge.sv
// Wishbone B4 pipelined slave to AXI4-Lite master bridge.
// One transaction in flight; timeout orphans the WB side while AXI completes.
module wb2axil_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                m_axi_aclk,
    input  logic                m_axi_aresetn,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [ADDR_W-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0]   wb_data_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    output logic                wb_stall_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [STRB_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                orphan_q, orphan_d;
    logic                stall_q;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                accept;
    logic                live;
    logic                resp_hs;
    logic                timeout_hit;

    assign accept  = (state_q == IDLE) && wb_cyc_i && wb_stb_i && !stall_q;
    assign live    = !orphan_q && wb_cyc_i;
    assign resp_hs = ((state_q == WR_RESP) && m_axi_bvalid)
                  || ((state_q == RD_RESP) && m_axi_rvalid);

    // Timeout fires once, on the TIMEOUT_CYC-th busy cycle, unless the response lands then.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q != IDLE) && live && !resp_hs
                      && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    assign m_axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_arvalid = (state_q == RD_REQ);
    assign m_axi_rready  = (state_q == RD_RESP);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = sel_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;

    assign wb_stall_o = stall_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_data_o  = rdata_q;

    // Next-state, capture, response pulses and orphan tracking.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        orphan_d  = orphan_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                cnt_d     = '0;
                if (accept) begin
                    addr_d  = wb_addr_i;
                    data_d  = wb_data_i;
                    sel_d   = wb_sel_i;
                    state_d = wb_we_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (m_axi_awready && !aw_done_q) aw_done_d = 1'b1;
                if (m_axi_wready && !w_done_q)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)       state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d = IDLE;
                    if (live) begin
                        ack_d = !m_axi_bresp[1];
                        err_d = m_axi_bresp[1];
                    end
                end
            end
            RD_REQ: begin
                if (m_axi_arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (m_axi_rvalid) begin
                    state_d = IDLE;
                    if (live) begin
                        ack_d = !m_axi_rresp[1];
                        err_d = m_axi_rresp[1];
                        if (!m_axi_rresp[1]) rdata_d = m_axi_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            if (!orphan_q) cnt_d = cnt_q + CNT_W'(1);
            if (timeout_hit) begin
                err_d    = 1'b1;
                orphan_d = 1'b1;
            end
            if (!wb_cyc_i) orphan_d = 1'b1;
        end
        if (state_d == IDLE) orphan_d = 1'b0;
    end

    // State and datapath registers.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            sel_q     <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            orphan_q  <= 1'b0;
            stall_q   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            orphan_q  <= orphan_d;
            stall_q   <= (state_d != IDLE);
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

endmodule
